// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch / data) in front of one single-port write-first block RAM.
// Optional performance counters are enabled by defining MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cancel,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic [3:0]        dm_wen,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       if_stall_cnt,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       forced_cnt
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    RESP_IDLE,
    RESP_IF,
    RESP_DM
  } resp_state_t;

  resp_state_t state_reg;
  resp_state_t state_next;
  logic [3:0]  starve_cnt_reg;
  logic [3:0]  starve_cnt_next;
  logic        force_if;

  // Only the word-address bits reach the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, if_addr[31:ADDR_W+2], if_addr[1:0],
                              dm_addr[31:ADDR_W+2], dm_addr[1:0]};

  // Grants are gated by resetn so they drop the moment reset asserts.
  always_comb begin
    force_if = resetn && if_req && !cancel && (starve_cnt_reg == LIMIT);
    dm_gnt   = resetn && dm_req && !force_if;
    if_gnt   = resetn && if_req && !cancel && !dm_gnt;
  end

  always_comb begin
    ram_en    = if_gnt | dm_gnt;
    ram_wen   = 4'b0000;
    ram_addr  = '0;
    ram_wdata = 32'h0;
    if (dm_gnt) begin
      ram_wen   = dm_wen;
      ram_addr  = dm_addr[ADDR_W+1:2];
      ram_wdata = dm_wdata;
    end else if (if_gnt) begin
      ram_addr  = if_addr[ADDR_W+1:2];
    end
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!if_req || cancel || if_gnt) begin
      starve_cnt_next = 4'd0;
    end else if (starve_cnt_reg < LIMIT) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end
  end

  // Stores complete at grant, so only reads leave a response pending.
  always_comb begin
    state_next = RESP_IDLE;
    if (if_gnt) begin
      state_next = RESP_IF;
    end else if (dm_gnt && (dm_wen == 4'b0000)) begin
      state_next = RESP_DM;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= RESP_IDLE;
      starve_cnt_reg <= 4'd0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  always_comb begin
    if_rvalid = (state_reg == RESP_IF) && !cancel;
    dm_rvalid = (state_reg == RESP_DM);
    if_rdata  = if_rvalid ? ram_rdata : 32'h0;
    dm_rdata  = dm_rvalid ? ram_rdata : 32'h0;
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] if_stall_cnt_reg;
  logic [31:0] conflict_cnt_reg;
  logic [31:0] forced_cnt_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_stall_cnt_reg <= 32'h0;
      conflict_cnt_reg <= 32'h0;
      forced_cnt_reg   <= 32'h0;
    end else begin
      if (if_req && !if_gnt && !cancel) begin
        if_stall_cnt_reg <= if_stall_cnt_reg + 32'd1;
      end
      if (if_req && dm_req) begin
        conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
      end
      if (force_if && if_gnt) begin
        forced_cnt_reg <= forced_cnt_reg + 32'd1;
      end
    end
  end

  assign if_stall_cnt = if_stall_cnt_reg;
  assign conflict_cnt = conflict_cnt_reg;
  assign forced_cnt   = forced_cnt_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with a behavioural RAM and reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 8;
  localparam int LIMIT  = 4;
  localparam int WORDS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              resetn;
  logic              cancel;
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              dm_req;
  logic [3:0]        dm_wen;
  logic [31:0]       dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [31:0]       dm_rdata;
  logic              ram_en;
  logic [3:0]        ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]       if_stall_cnt;
  logic [31:0]       conflict_cnt;
  logic [31:0]       forced_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn), .cancel(cancel),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
    , .if_stall_cnt(if_stall_cnt), .conflict_cnt(conflict_cnt), .forced_cnt(forced_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] wen,
                                        input logic [31:0] data);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (wen[b]) w[b*8 +: 8] = data[b*8 +: 8];
    return w;
  endfunction

  // Behavioural write-first RAM attached to the DUT.
  logic [31:0] ram_mem [WORDS];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_mem[ram_addr] <= merge(ram_mem[ram_addr], ram_wen, ram_wdata);
      ram_rdata         <= merge(ram_mem[ram_addr], ram_wen, ram_wdata);
    end
  end

  // Reference model state.
  logic [31:0] gold [WORDS];
  int          denied_run;
  int          pend_kind;      // 0 none, 1 fetch, 2 data load
  logic [31:0] pend_data;
  int          m_stall, m_conflict, m_forced;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic last_if_gnt, last_dm_gnt, last_if_rvalid, last_dm_rvalid;
  logic [31:0] last_if_rdata, last_dm_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    denied_run = 0;
    pend_kind  = 0;
    pend_data  = 32'h0;
    m_stall    = 0;
    m_conflict = 0;
    m_forced   = 0;
  endtask

  task automatic step(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                      input logic [3:0] dwen, input logic [31:0] daddr,
                      input logic [31:0] dwdata, input logic canc);
    logic e_force, e_dm, e_if, e_ifrv, e_dmrv;
    int   widx;
    @(negedge clk);
    if_req = ireq; if_addr = iaddr; dm_req = dreq; dm_wen = dwen;
    dm_addr = daddr; dm_wdata = dwdata; cancel = canc;
    #1;
    e_force = (denied_run >= LIMIT) && ireq && !canc;
    e_dm    = dreq && !e_force;
    e_if    = ireq && !canc && !e_dm;
    e_ifrv  = (pend_kind == 1) && !canc;
    e_dmrv  = (pend_kind == 2);
    widx    = e_dm ? int'(daddr[ADDR_W+1:2]) : int'(iaddr[ADDR_W+1:2]);
    check("if_gnt", 32'(if_gnt), 32'(e_if));
    check("dm_gnt", 32'(dm_gnt), 32'(e_dm));
    check("ram_en", 32'(ram_en), 32'(e_if || e_dm));
    check("ram_wen", 32'(ram_wen), e_dm ? 32'(dwen) : 32'h0);
    check("ram_addr", 32'(ram_addr), (e_if || e_dm) ? 32'(widx) : 32'h0);
    if (e_dm || !e_if) check("ram_wdata", ram_wdata, e_dm ? dwdata : 32'h0);
    check("if_rvalid", 32'(if_rvalid), 32'(e_ifrv));
    check("if_rdata", if_rdata, e_ifrv ? pend_data : 32'h0);
    check("dm_rvalid", 32'(dm_rvalid), 32'(e_dmrv));
    check("dm_rdata", dm_rdata, e_dmrv ? pend_data : 32'h0);
    $display("cyc %0d if_req=%0b if_addr=%h dm_req=%0b wen=%h dm_addr=%h cancel=%0b -> if_gnt=%0b dm_gnt=%0b if_rv=%0b if_rd=%h dm_rv=%0b dm_rd=%h",
             cyc, ireq, iaddr, dreq, dwen, daddr, canc, if_gnt, dm_gnt,
             if_rvalid, if_rdata, dm_rvalid, dm_rdata);
    last_if_gnt = if_gnt; last_dm_gnt = dm_gnt;
    last_if_rvalid = if_rvalid; last_dm_rvalid = dm_rvalid;
    last_if_rdata = if_rdata; last_dm_rdata = dm_rdata;
    @(posedge clk);
    #1;
    cyc++;
    pend_kind = 0;
    if (e_if) begin
      pend_kind = 1;
      pend_data = gold[widx];
    end else if (e_dm) begin
      if (dwen == 4'b0000) begin
        pend_kind = 2;
        pend_data = gold[widx];
      end else begin
        gold[widx] = merge(gold[widx], dwen, dwdata);
      end
    end
    if (ireq && !e_if && !canc) begin
      m_stall++;
      denied_run = (denied_run < LIMIT) ? denied_run + 1 : LIMIT;
    end else begin
      denied_run = 0;
    end
    if (ireq && dreq) m_conflict++;
    if (e_force) m_forced++;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  logic        p_if, p_dm;
  logic [31:0] r_iaddr, r_daddr, r_wdata;
  logic [3:0]  r_wen;

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      gold[i]    = $urandom;
      ram_mem[i] = gold[i];
    end
    gold[4] = 32'hCAFE_0004; ram_mem[4] = 32'hCAFE_0004;
    gold[8] = 32'h1122_3344; ram_mem[8] = 32'h1122_3344;
    model_reset();

    // Reset state with both requests asserted.
    resetn = 1'b0; cancel = 1'b0;
    if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_wen = 4'h0;
    dm_addr = 32'h20; dm_wdata = 32'h0;
    #12;
    check("rst_if_gnt", 32'(if_gnt), 32'h0);
    check("rst_dm_gnt", 32'(dm_gnt), 32'h0);
    check("rst_ram_en", 32'(ram_en), 32'h0);
    check("rst_rvalid", 32'({if_rvalid, dm_rvalid}), 32'h0);
    @(negedge clk);
    if_req = 1'b0; dm_req = 1'b0;
    resetn = 1'b1;

    // Single fetch from byte address 0x10.
    step(1'b1, 32'h0000_0010, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    check("fetch_gnt", 32'(last_if_gnt), 32'h1);
    idle();
    check("fetch_rvalid", 32'(last_if_rvalid), 32'h1);
    check("fetch_rdata", last_if_rdata, 32'hCAFE_0004);

    // Partial store then load of the same word.
    step(1'b0, 32'h0, 1'b1, 4'b0011, 32'h20, 32'hAABB_CCDD, 1'b0);
    step(1'b0, 32'h0, 1'b1, 4'b0000, 32'h20, 32'h0, 1'b0);
    check("store_no_rvalid", 32'(last_dm_rvalid), 32'h0);
    idle();
    check("load_rvalid", 32'(last_dm_rvalid), 32'h1);
    check("load_rdata", last_dm_rdata, 32'h1122_CCDD);

    // Cancel drops the in-flight fetch response and blocks the grant.
    step(1'b1, 32'h30, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h30, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    check("cancel_rvalid", 32'(last_if_rvalid), 32'h0);
    check("cancel_gnt", 32'(last_if_gnt), 32'h0);
    step(1'b1, 32'h30, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    check("after_cancel_gnt", 32'(last_if_gnt), 32'h1);
    idle();

    // Reset while a load response is pending.
    step(1'b0, 32'h0, 1'b1, 4'h0, 32'h44, 32'h0, 1'b0);
    resetn = 1'b0;
    #1;
    check("rst_mid_dm_rvalid", 32'(dm_rvalid), 32'h0);
    check("rst_mid_dm_gnt", 32'(dm_gnt), 32'h0);
    model_reset();
    @(negedge clk);
    dm_req = 1'b0;
    resetn = 1'b1;
    idle();
    check("rst_no_stale", 32'(last_dm_rvalid), 32'h0);

    // Sustained conflict: fetch is forced through every fifth cycle.
    for (int c = 1; c <= 10; c++) begin
      step(1'b1, 32'h40, 1'b1, 4'h0, 32'h80, 32'h0, 1'b0);
      check("conflict_if_gnt", 32'(last_if_gnt), 32'((c == 5) || (c == 10)));
    end
`ifdef MEM_ARB_PERF_CNT_EN
    check("perf_conflict", conflict_cnt, 32'd10);
    check("perf_forced", forced_cnt, 32'd2);
    check("perf_stall", if_stall_cnt, 32'd8);
`endif
    idle();

    // Random traffic; requesters hold their request until granted (or drop it).
    p_if = 1'b0; p_dm = 1'b0;
    r_iaddr = 32'h0; r_daddr = 32'h0; r_wdata = 32'h0; r_wen = 4'h0;
    for (int n = 0; n < 300; n++) begin
      if (!p_if && ($urandom_range(0, 1) == 1)) begin
        p_if = 1'b1;
        r_iaddr = {$urandom_range(0, 255) << 10} | (32'($urandom_range(0, 15)) << 2);
      end else if (p_if && ($urandom_range(0, 15) == 0)) begin
        p_if = 1'b0;
      end
      if (!p_dm && ($urandom_range(0, 2) != 0)) begin
        p_dm = 1'b1;
        r_daddr = {$urandom_range(0, 255) << 10} | (32'($urandom_range(0, 15)) << 2)
                  | 32'($urandom_range(0, 3));
        r_wen   = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : 4'h0;
        r_wdata = $urandom;
      end
      step(p_if, r_iaddr, p_dm, r_wen, r_daddr, r_wdata, $urandom_range(0, 9) == 0);
      if (last_if_gnt) p_if = 1'b0;
      if (last_dm_gnt) p_dm = 1'b0;
    end
    idle();
`ifdef MEM_ARB_PERF_CNT_EN
    check("perf_conflict_end", conflict_cnt, 32'(m_conflict));
    check("perf_forced_end", forced_cnt, 32'(m_forced));
    check("perf_stall_end", if_stall_cnt, 32'(m_stall));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
